// File: rtl/uart_pkg.sv
// Shared encodings and width helpers for the UART transmit arbiter
// and related bus arbiters.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  // Bits needed to hold any value 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to index n requesters.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: when locked only the owner may win,
// otherwise the first active request above the pointer (wrapping) wins.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr,
  input  logic            lock,
  input  logic [PW-1:0]   owner,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   pick_idx,
  output logic            found
);

  logic [PW-1:0] w_idx;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    w_idx    = '0;
    if (lock) begin
      if (req[owner]) begin
        pick[owner] = 1'b1;
        pick_idx    = owner;
        found       = 1'b1;
      end
    end else begin
      // The pointer's own slot is searched last, giving the previous winner lowest priority.
      for (int k = 1; k <= NREQ; k++) begin
        w_idx = PW'((int'(rr) + k) % NREQ);
        if (!found && req[w_idx]) begin
          pick[w_idx] = 1'b1;
          pick_idx    = w_idx;
          found       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Message-level round-robin arbiter feeding bytes from NREQ requesters
// into the single rxtx transmit handshake (tx_vld / tx_data / txrdy).
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int LOCK_TO = 1023,
  parameter int ACK_TO  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_rdy,
  output logic              tx_vld,
  output logic [7:0]        tx_data,
  input  logic              txrdy,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int PW = idx_width(NREQ);
  localparam int LW = cnt_width(LOCK_TO);
  localparam int AW = cnt_width(ACK_TO);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TO - 1);
  localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TO - 1);

  state_t        r_state;
  logic          r_tx_vld;
  logic [7:0]    r_tx_data;
  logic          r_lock;
  logic [PW-1:0] r_owner;
  logic [PW-1:0] r_rr;
  logic [PW-1:0] r_g;
  logic [LW-1:0] r_lock_cnt;
  logic [AW-1:0] r_ack_cnt;

  logic [NREQ-1:0] w_pick;
  logic [PW-1:0]   w_idx;
  logic            w_found;
  logic [NREQ-1:0] w_rdy;
  logic            w_accept;
  logic [7:0]      w_data;
  logic            w_last;

  rr_pick #(
    .NREQ(NREQ),
    .PW  (PW)
  ) u_pick (
    .req     (req_vld),
    .rr      (r_rr),
    .lock    (r_lock),
    .owner   (r_owner),
    .pick    (w_pick),
    .pick_idx(w_idx),
    .found   (w_found)
  );

  always_comb begin
    w_data = '0;
    w_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick[i]) begin
        w_data = req_data[8*i +: 8];
        w_last = req_last[i];
      end
    end
  end

  // Offer a slot only while the transmitter is idle so no byte is launched into a busy rxtx.
  assign w_rdy    = (r_state == ST_IDLE && txrdy && w_found) ? w_pick : '0;
  assign w_accept = |(w_rdy & req_vld);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tx_vld   <= 1'b0;
      r_tx_data  <= 8'h00;
      r_lock     <= 1'b0;
      r_owner    <= '0;
      r_rr       <= '0;
      r_g        <= '0;
      r_lock_cnt <= '0;
      r_ack_cnt  <= '0;
    end else begin
      r_tx_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_tx_data  <= w_data;
            r_g        <= w_idx;
            r_tx_vld   <= 1'b1;
            r_lock_cnt <= '0;
            r_ack_cnt  <= '0;
            r_state    <= ST_SEND;
            if (w_last) begin
              r_lock <= 1'b0;
              r_rr   <= w_idx;
            end else begin
              r_lock  <= 1'b1;
              r_owner <= w_idx;
            end
          end else if (r_lock && !req_vld[r_owner]) begin
            // A stalled owner gives up the lock and counts as the last winner.
            if (r_lock_cnt == LOCK_LAST) begin
              r_lock     <= 1'b0;
              r_rr       <= r_owner;
              r_lock_cnt <= '0;
            end else begin
              r_lock_cnt <= r_lock_cnt + 1'b1;
            end
          end
        end
        ST_SEND: begin
          r_ack_cnt <= '0;
          r_state   <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (!txrdy || r_ack_cnt == ACK_LAST) begin
            r_state <= ST_WAIT_DONE;
          end else begin
            r_ack_cnt <= r_ack_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (txrdy) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_rdy = w_rdy;
  assign tx_vld  = r_tx_vld;
  assign tx_data = r_tx_data;
  assign busy    = (r_state != ST_IDLE) || r_lock;

  always_comb begin
    grant = '0;
    if (r_state != ST_IDLE) begin
      grant = NREQ'(1) << r_g;
    end else if (r_lock) begin
      grant = NREQ'(1) << r_owner;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: requester queues, a simple rxtx model,
// and expected-byte queue compared at each tx_vld pulse.
module tb_uart_tx_arb;

  localparam int NREQ = 2;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } ent_t;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] d;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_vld;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_rdy;
  logic              tx_vld;
  logic [7:0]        tx_data;
  logic              txrdy;
  logic [NREQ-1:0]   grant;
  logic              busy;

  ent_t src_q[2][$];
  exp_t exp_q[$];
  int   acc_q[$];
  int   rise_q[$];

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   last_acc = -100;
  int   rdy0_cnt = 0;
  int   model_cnt = 0;
  int   hold = 4;
  bit   ack_ignore = 1'b0;
  logic prev_tx_vld = 1'b0;
  logic prev_txrdy = 1'b1;

  uart_tx_arb #(
    .NREQ   (NREQ),
    .LOCK_TO(16),
    .ACK_TO (15)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_vld (req_vld),
    .req_data(req_data),
    .req_last(req_last),
    .req_rdy (req_rdy),
    .tx_vld  (tx_vld),
    .tx_data (tx_data),
    .txrdy   (txrdy),
    .grant   (grant),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push_src(input int i, input logic [7:0] d, input logic last);
    ent_t e;
    e.d = d;
    e.last = last;
    src_q[i].push_back(e);
  endtask

  task automatic push_exp(input int i, input logic [7:0] d);
    exp_t e;
    e.src = 2'(i);
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic clear_log();
    acc_q.delete();
    rise_q.delete();
    rdy0_cnt = 0;
  endtask

  task automatic drain(input int budget, input string tag);
    int c = 0;
    while ((exp_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0 ||
            req_vld != '0 || busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, c < budget, 1);
  endtask

  // Requester drivers, rxtx model and output monitor.
  initial begin
    exp_t e;
    ent_t t;
    logic [NREQ-1:0] fire;
    req_vld  = '0;
    req_data = '0;
    req_last = '0;
    txrdy    = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_vld) begin
        chk("tx_latency", cyc - last_acc, 1);
        chk("tx_pulse", prev_tx_vld, 0);
        if (exp_q.size() == 0) begin
          chk("tx_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", tx_data, e.d);
          chk("tx_grant", grant, 1 << e.src);
        end
      end
      prev_tx_vld = tx_vld;
      chk("rdy_onehot", $countones(req_rdy) <= 1, 1);
      if (!txrdy) chk("rdy_txbusy", req_rdy, 0);
      if (req_rdy[0]) rdy0_cnt++;
      fire = req_vld & req_rdy;
      if (fire != '0) begin
        acc_q.push_back(cyc);
        last_acc = cyc;
      end
      if (txrdy && !prev_txrdy) rise_q.push_back(cyc);
      prev_txrdy = txrdy;
      if (tx_vld && !ack_ignore) model_cnt = hold;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (fire[i] && src_q[i].size() != 0) t = src_q[i].pop_front();
        if (src_q[i].size() != 0) begin
          req_vld[i]         = 1'b1;
          req_data[8*i +: 8] = src_q[i][0].d;
          req_last[i]        = src_q[i][0].last;
        end else begin
          req_vld[i]         = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
      if (model_cnt > 0) begin
        txrdy = 1'b0;
        model_cnt--;
      end else begin
        txrdy = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int d;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_vld", tx_vld, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);

    // Single requester, long frame: next accept one cycle after txrdy rises.
    clear_log();
    hold = 100;
    push_src(0, 8'h41, 1'b1);
    push_src(0, 8'h42, 1'b1);
    push_exp(0, 8'h41);
    push_exp(0, 8'h42);
    drain(600, "t1_drain");
    chk("t1_rdy0_cycles", rdy0_cnt, 2);
    chk("t1_nacc", acc_q.size(), 2);
    d = (acc_q.size() > 1 && rise_q.size() > 0) ? acc_q[1] - rise_q[0] : -1;
    chk("t1_acc_after_rise", d, 1);

    // Contention with single-byte messages: strict alternation starting at req1.
    clear_log();
    hold = 4;
    for (int k = 0; k < 3; k++) begin
      push_src(0, 8'h10 + 8'(k), 1'b1);
      push_src(1, 8'h20 + 8'(k), 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      push_exp(1, 8'h20 + 8'(k));
      push_exp(0, 8'h10 + 8'(k));
    end
    drain(400, "t2_drain");
    chk("t2_nacc", acc_q.size(), 6);

    // Message lock: req0's three-byte message is not interleaved with req1.
    clear_log();
    push_src(1, 8'h30, 1'b1);
    push_src(1, 8'h31, 1'b1);
    push_src(0, 8'hA0, 1'b0);
    push_src(0, 8'hA1, 1'b0);
    push_src(0, 8'hA2, 1'b1);
    push_exp(1, 8'h30);
    push_exp(0, 8'hA0);
    push_exp(0, 8'hA1);
    push_exp(0, 8'hA2);
    push_exp(1, 8'h31);
    drain(400, "t3_drain");

    // Lock timeout: req0 stalls mid-message, req1 waits out 16 idle cycles.
    clear_log();
    push_src(0, 8'h55, 1'b0);
    push_src(1, 8'h66, 1'b1);
    push_exp(0, 8'h55);
    push_exp(1, 8'h66);
    c = 0;
    while (rise_q.size() == 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("t4_rise_seen", c < 200, 1);
    repeat (5) @(negedge clk);
    chk("t4_locked_grant", grant, 2'b01);
    chk("t4_locked_busy", busy, 1);
    chk("t4_locked_rdy", req_rdy, 0);
    drain(400, "t4_drain");
    d = (acc_q.size() > 1 && rise_q.size() > 0) ? acc_q[1] - rise_q[0] : -1;
    chk("t4_release_gap", d, 17);

    // ACK timeout: rxtx never drops txrdy.
    clear_log();
    ack_ignore = 1'b1;
    push_src(0, 8'h77, 1'b1);
    push_src(0, 8'h78, 1'b1);
    push_exp(0, 8'h77);
    push_exp(0, 8'h78);
    drain(400, "t5_drain");
    d = (acc_q.size() > 1) ? acc_q[1] - acc_q[0] : -1;
    chk("t5_ack_to_gap", d, 18);
    ack_ignore = 1'b0;

    // Reset during WAIT_DONE while a lock is held.
    clear_log();
    hold = 100;
    push_src(1, 8'h88, 1'b0);
    push_exp(1, 8'h88);
    c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("t6_tx_seen", c < 100, 1);
    repeat (10) @(negedge clk);
    chk("t6_pre_busy", busy, 1);
    chk("t6_pre_grant", grant, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_tx_vld", tx_vld, 0);
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_tx_data", tx_data, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_post_busy", busy, 0);
    push_src(0, 8'h99, 1'b1);
    push_exp(0, 8'h99);
    drain(600, "t6_drain");

    chk("exp_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Arbitrates NREQ byte-stream requesters onto the single transmit port of the rxtx UART core (tx_vld / tx_data / txrdy).
- Sits between the requesters (CPU bus bridge, debug/trace engine, ...) and the rxtx instance.
- Round-robin arbitration per message. A message is a run of bytes ending in a byte with req_last=1; the grant is held for the whole message.
- Sequences each byte through the rxtx handshake so that no byte is launched while the transmitter is busy.

Parameters:
- NREQ, 2, number of requesters (2..4).
- LOCK_TO, 1023, idle cycles in IDLE after which a held message lock is abandoned.
- ACK_TO, 15, cycles allowed in WAIT_ACK for txrdy to fall before the byte is deemed accepted anyway.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- req_vld  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NREQ  per-requester end-of-message flag, qualified by req_vld.
- req_rdy  out  NREQ  per-requester accept strobe; one-hot or zero.
- tx_vld  out  1  one-cycle launch pulse to rxtx.
- tx_data  out  8  byte to rxtx; stable from the tx_vld cycle until the next accept.
- txrdy  in  1  rxtx transmitter idle (1 = ready).
- grant  out  NREQ  one-hot current or locked owner; 0 when none.
- busy  out  1  high in any state other than IDLE, or while locked.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, tx_vld=0, tx_data=8'h00, req_rdy=0, grant=0, lock=0, rr pointer=0, timers=0.
- States: IDLE, SEND, WAIT_ACK, WAIT_DONE.
- IDLE, accept: if txrdy=1 and a candidate exists, req_rdy[g]=1 combinationally for that cycle.
  - The byte is accepted when req_vld[g] & req_rdy[g].
  - tx_data is registered from req_data[g], and last_q from req_last[g].
  - Next state is SEND.
- Candidate selection:
  - Locked: only the owner is a candidate.
  - Unlocked: the first requester with req_vld=1, searching upward (wrapping) from rr+1.
- SEND: tx_vld=1 for exactly this one cycle. Next state is WAIT_ACK.
- WAIT_ACK:
  - Exit to WAIT_DONE on txrdy=0.
  - Also exit to WAIT_DONE if ACK_TO cycles elapse; txrdy is then treated as already cycled.
- WAIT_DONE: exit to IDLE on txrdy=1.
- Lock update at accept:
  - last=0: lock=1, owner=g.
  - last=1: lock=0, rr=g.
- Lock timeout: while locked in IDLE with req_vld[owner]=0, a counter increments. At LOCK_TO the lock clears, rr=owner, and the counter is cleared. The counter also clears on every accept.
- Latency: accept at cycle N, tx_vld at N+1. Minimum spacing between accepts is 4 cycles plus the rxtx frame time.
- Simultaneous requests: exactly one req_rdy bit is high. Round-robin is fair, with at most NREQ-1 messages waiting.
- req_vld falling without acceptance is legal; the arbiter re-selects each cycle while unlocked.
- txrdy=0 in IDLE: no req_rdy is asserted; the arbiter waits.
- Async reset mid-frame: all state returns to reset values. The byte in rxtx is not tracked further.
- grant equals onehot(owner) while locked, onehot(g) from accept through WAIT_DONE, and 0 otherwise.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams: ST_IDLE=2'd0, ST_SEND=2'd1, ST_WAIT_ACK=2'd2, ST_WAIT_DONE=2'd3.
  - function/constant for counter widths: clog2 of LOCK_TO and ACK_TO.
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: req mask (NREQ), rr pointer, lock, owner.
  - Outputs: one-hot pick and a found flag.
  - Reused by later bus arbiters.

Test Plan:
- Single requester: req0 sends 8'h41 with last=1, rxtx model holds txrdy low 100 cycles after tx_vld → one tx_vld pulse carrying 8'h41, req_rdy[0] high for 1 cycle, next accept no earlier than txrdy rising +1.
- Contention: req0 and req1 both valid with single-byte messages 8'h10 and 8'h20, rr=0 → order is req1 then req0. Repeat → strict alternation.
- Message lock: req0 sends 3 bytes 8'hA0..8'hA2 (last only on A2) while req1 is continuously valid → all three req0 bytes precede any req1 byte.
- Lock timeout: req0 sends 8'h55 with last=0 then drops valid, LOCK_TO=16 → lock released after 16 IDLE cycles, then req1 is granted.
- ACK timeout: rxtx model keeps txrdy=1 after tx_vld → FSM leaves WAIT_ACK after 15 cycles, returns to IDLE, next byte accepted.
- Reset mid-frame: rst_n low during WAIT_DONE → tx_vld=0, grant=0, busy=0, lock=0 immediately; normal operation after release.
